complete_stage: RTL and testbench

// - Completion/CDB stage downstream of execute, upstream of the ROB/RS/issue top.
// - Collects up to N_WAY execute results per cycle and buffers overflow in an in-order circular buffer.
// - Each cycle, broadcasts up to N_WAY results, oldest first.
// - Drives complete_dest_tag (ROB/RS wakeup) and wr_en/wr_idx/wr_data (regfile write).

---
 rtl/complete_stage.sv | 193 +++++++++++++++++++
 tb/tb_complete_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/complete_stage.sv
// Completion / CDB stage: merges execute results with an in-order overflow buffer and
// broadcasts up to N_WAY results per cycle, oldest first. Optional stats: COMPLETE_STATS_EN.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module complete_stage_chk #(
  parameter int CB_DEPTH = 4,
  parameter int CNT_W    = 3
) (
  input logic             clock,
  input logic             reset,
  input logic [CNT_W-1:0] cb_count
);
  a_cb_count_bound: assert property (@(posedge clock) disable iff (reset) int'(cb_count) <= CB_DEPTH);
endmodule

module complete_stage #(
  parameter int N_WAY    = `N_WAY,
  parameter int CDB_BITS = `CDB_BITS,
  parameter int XLEN     = `XLEN,
  parameter int CB_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_WAY-1:0]          ex_valid,
  input  logic [N_WAY*CDB_BITS-1:0] ex_dest_tag,
  input  logic [N_WAY*XLEN-1:0]     ex_result,
  output logic                      ex_ready,
  output logic [N_WAY*CDB_BITS-1:0] complete_dest_tag,
  output logic [N_WAY-1:0]          wr_en,
  output logic [N_WAY*CDB_BITS-1:0] wr_idx,
  output logic [N_WAY*XLEN-1:0]     wr_data,
  output logic [$clog2(CB_DEPTH):0] cb_count
`ifdef COMPLETE_STATS_EN
  ,
  output logic [31:0]               stat_completions,
  output logic [31:0]               stat_stall_cycles
`endif
);
  localparam int PTR_W = $clog2(CB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]                   head_r, tail_r;
  logic [CNT_W-1:0]                   count_r;
  logic [CDB_BITS-1:0]                cb_tag_r   [CB_DEPTH];
  logic [XLEN-1:0]                    cb_data_r  [CB_DEPTH];
  logic [N_WAY-1:0][CDB_BITS-1:0]     out_tag_r, nxt_tag_s;
  logic [N_WAY-1:0][XLEN-1:0]         out_data_r, nxt_data_s;
  logic [N_WAY-1:0]                   out_en_r, nxt_en_s;
  logic [N_WAY-1:0]                   accept_s;
  logic [CB_DEPTH-1:0]                cb_we_s;
  logic [CDB_BITS-1:0]                cb_wtag_s  [CB_DEPTH];
  logic [XLEN-1:0]                    cb_wdata_s [CB_DEPTH];
  logic [CNT_W-1:0]                   consumed_s, written_s;

  // Readiness depends only on registered occupancy, so no input-to-ready path exists.
  always_comb begin
    ex_ready = !reset && ((CB_DEPTH - int'(count_r)) >= N_WAY);
    for (int i = 0; i < N_WAY; i++) begin
      accept_s[i] = ex_valid[i] && ex_ready && (ex_dest_tag[i*CDB_BITS +: CDB_BITS] != {CDB_BITS{1'b0}});
    end
  end

  // Candidate selection: buffered entries first, then accepted lanes in index order;
  // each accepted lane's rank decides whether it broadcasts or spills to the tail.
  always_comb begin
    int               n_buf;
    int               rank [N_WAY];
    int               pos;
    logic [PTR_W-1:0] idx;
    nxt_tag_s  = '0;
    nxt_data_s = '0;
    nxt_en_s   = {N_WAY{1'b0}};
    cb_we_s    = {CB_DEPTH{1'b0}};
    for (int e = 0; e < CB_DEPTH; e++) begin
      cb_wtag_s[e]  = {CDB_BITS{1'b0}};
      cb_wdata_s[e] = {XLEN{1'b0}};
    end
    idx   = {PTR_W{1'b0}};
    n_buf = (int'(count_r) > N_WAY) ? N_WAY : int'(count_r);
    for (int o = 0; o < N_WAY; o++) begin
      idx = head_r + PTR_W'(o);
      if (o < n_buf) begin
        nxt_tag_s[o]  = cb_tag_r[idx];
        nxt_data_s[o] = cb_data_r[idx];
        nxt_en_s[o]   = 1'b1;
      end else begin
        nxt_en_s[o]   = 1'b0;
      end
    end
    pos = n_buf;
    for (int i = 0; i < N_WAY; i++) begin
      rank[i] = pos;
      if (accept_s[i]) begin
        pos = pos + 1;
      end else begin
        pos = pos;
      end
    end
    for (int i = 0; i < N_WAY; i++) begin
      for (int o = 0; o < N_WAY; o++) begin
        if (accept_s[i] && (rank[i] == o)) begin
          nxt_tag_s[o]  = ex_dest_tag[i*CDB_BITS +: CDB_BITS];
          nxt_data_s[o] = ex_result[i*XLEN +: XLEN];
          nxt_en_s[o]   = 1'b1;
        end else begin
          nxt_en_s[o]   = nxt_en_s[o];
        end
      end
      for (int e = 0; e < CB_DEPTH; e++) begin
        if (accept_s[i] && (rank[i] >= N_WAY) && ((tail_r + PTR_W'(rank[i] - N_WAY)) == PTR_W'(e))) begin
          cb_we_s[e]    = 1'b1;
          cb_wtag_s[e]  = ex_dest_tag[i*CDB_BITS +: CDB_BITS];
          cb_wdata_s[e] = ex_result[i*XLEN +: XLEN];
        end else begin
          cb_we_s[e]    = cb_we_s[e];
        end
      end
    end
    consumed_s = CNT_W'(n_buf);
    written_s  = (pos > N_WAY) ? CNT_W'(pos - N_WAY) : {CNT_W{1'b0}};
  end

  // Buffer pointers, storage and registered broadcast lanes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      out_tag_r  <= '0;
      out_data_r <= '0;
      out_en_r   <= {N_WAY{1'b0}};
      for (int e = 0; e < CB_DEPTH; e++) begin
        cb_tag_r[e]  <= {CDB_BITS{1'b0}};
        cb_data_r[e] <= {XLEN{1'b0}};
      end
    end else begin
      head_r     <= head_r + consumed_s[PTR_W-1:0];
      tail_r     <= tail_r + written_s[PTR_W-1:0];
      count_r    <= count_r + written_s - consumed_s;
      out_tag_r  <= nxt_tag_s;
      out_data_r <= nxt_data_s;
      out_en_r   <= nxt_en_s;
      for (int e = 0; e < CB_DEPTH; e++) begin
        if (cb_we_s[e]) begin
          cb_tag_r[e]  <= cb_wtag_s[e];
          cb_data_r[e] <= cb_wdata_s[e];
        end
      end
    end
  end

  assign complete_dest_tag = out_tag_r;
  assign wr_idx            = out_tag_r;
  assign wr_data           = out_data_r;
  assign wr_en             = out_en_r;
  assign cb_count          = count_r;

`ifdef COMPLETE_STATS_EN
  function automatic logic [31:0] popcount(input logic [N_WAY-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < N_WAY; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // Completions counted at the edge that loads them onto the bus; both counters wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_completions  <= 32'd0;
      stat_stall_cycles <= 32'd0;
    end else begin
      stat_completions  <= stat_completions + popcount(nxt_en_s);
      stat_stall_cycles <= stat_stall_cycles + {31'd0, (!ex_ready && (|ex_valid))};
    end
  end
`endif

  complete_stage_chk #(.CB_DEPTH(CB_DEPTH), .CNT_W(CNT_W)) u_chk (
    .clock    (clock),
    .reset    (reset),
    .cb_count (count_r)
  );
endmodule

// File: tb/tb_complete_stage.sv
// Randomized scoreboard bench for complete_stage (N_WAY=2, CB_DEPTH=4).
module tb_complete_stage;
  localparam int NW = 2, TB = 6, XL = 32, CBD = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NW-1:0]     ex_valid = '0;
  logic [NW*TB-1:0]  ex_dest_tag = '0;
  logic [NW*XL-1:0]  ex_result = '0;
  logic              ex_ready;
  logic [NW*TB-1:0]  complete_dest_tag;
  logic [NW-1:0]     wr_en;
  logic [NW*TB-1:0]  wr_idx;
  logic [NW*XL-1:0]  wr_data;
  logic [2:0]        cb_count;

  complete_stage #(.N_WAY(NW), .CDB_BITS(TB), .XLEN(XL), .CB_DEPTH(CBD)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_dest_tag(ex_dest_tag),
    .ex_result(ex_result), .ex_ready(ex_ready), .complete_dest_tag(complete_dest_tag),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .cb_count(cb_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [TB-1:0] tag; logic [XL-1:0] data; } res_t;
  res_t exp_q[$];
  int   bcnt_q[$];
  int   pend_q[$];
  int   pend = 0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of accepted results; the stage emits up to NW per cycle.
  task automatic step(input logic [1:0] v, input logic [TB-1:0] t0, input logic [TB-1:0] t1,
                      input logic [XL-1:0] d0, input logic [XL-1:0] d1);
    bit exp_ready;
    int nacc, total, b;
    logic [TB-1:0] t [2];
    logic [XL-1:0] d [2];
    t[0] = t0; t[1] = t1; d[0] = d0; d[1] = d1;
    exp_ready = ((CBD - pend) >= NW);
    chk("ex_ready", {63'd0, ex_ready}, {63'd0, exp_ready});
    ex_valid    = v;
    ex_dest_tag = {t1, t0};
    ex_result   = {d1, d0};
    nacc = 0;
    for (int i = 0; i < NW; i++) begin
      if (v[i] && exp_ready && t[i] != '0) begin
        exp_q.push_back('{tag: t[i], data: d[i]});
        nacc++;
      end
    end
    total = pend + nacc;
    b = (total < NW) ? total : NW;
    pend = total - b;
    bcnt_q.push_back(b);
    pend_q.push_back(pend);
  endtask

  task automatic rand_step(input int zero_pct);
    logic [TB-1:0] t0, t1;
    t0 = ($urandom_range(0, 99) < zero_pct) ? 6'd0 : 6'($urandom_range(1, 63));
    t1 = ($urandom_range(0, 99) < zero_pct) ? 6'd0 : 6'($urandom_range(1, 63));
    step(2'($urandom_range(0, 3)), t0, t1, $urandom, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clock);
    ex_valid    = 2'b11;
    ex_dest_tag = 12'($urandom) | 12'h041;
    ex_result   = {$urandom, $urandom};
    #2;
    reset  = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("rst_tag", 64'(complete_dest_tag), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_idx", 64'(wr_idx), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd0);
    chk("rst_cb_count", 64'(cb_count), 64'd0);
    exp_q.delete();
    bcnt_q.delete();
    pend_q.delete();
    pend = 0;
    repeat (2) @(negedge clock);
    reset    = 1'b0;
    ex_valid = '0;
    #1;
    mon_en = 1'b1;
    step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
  endtask

  // Monitor: one expectation record per clock edge while enabled.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (mon_en) begin
        if (bcnt_q.size() == 0) begin
          chk("sb_sync", 64'd0, 64'd1);
        end else begin
          int b, p;
          b = bcnt_q.pop_front();
          p = pend_q.pop_front();
          chk("cb_count", 64'(cb_count), 64'(p));
          for (int l = 0; l < NW; l++) begin
            if (l < b) begin
              chk("lane_en", 64'(wr_en[l]), 64'd1);
              if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'd0, 64'd1);
              end else begin
                res_t r;
                r = exp_q.pop_front();
                chk("lane_tag", 64'(complete_dest_tag[l*TB +: TB]), 64'(r.tag));
                chk("lane_idx", 64'(wr_idx[l*TB +: TB]), 64'(r.tag));
                chk("lane_data", 64'(wr_data[l*XL +: XL]), 64'(r.data));
              end
            end else begin
              chk("idle_en", 64'(wr_en[l]), 64'd0);
              chk("idle_tag", 64'(complete_dest_tag[l*TB +: TB]), 64'd0);
              chk("idle_idx", 64'(wr_idx[l*TB +: TB]), 64'd0);
              chk("idle_data", 64'(wr_data[l*XL +: XL]), 64'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    do_reset();
    @(negedge clock); step(2'b11, 6'd5, 6'd9, 32'hA, 32'hB);
    @(negedge clock); step(2'b11, 6'd0, 6'd7, 32'h11, 32'h22);
    @(negedge clock); step(2'b10, 6'd3, 6'd12, 32'h33, 32'h44);
    @(negedge clock); step(2'b01, 6'd63, 6'd1, 32'hFFFF_FFFF, 32'h55);
    @(negedge clock); step(2'b00, 6'd8, 6'd8, 32'h66, 32'h77);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      step(2'b11, 6'($urandom_range(1, 63)), 6'($urandom_range(1, 63)), $urandom, $urandom);
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      rand_step(25);
    end
    @(negedge clock); step(2'b11, 6'd21, 6'd22, 32'hDEAD, 32'hBEEF);
    do_reset();
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      rand_step(10);
    end
    repeat (3) begin
      @(negedge clock);
      step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
    end
    @(posedge clock);
    #2;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
